fetch_sequencer: RTL and testbench

Sequencer that owns the program counter and drives the instruction memory for the single-cycle RISC-V datapath. It loads a program into memory through a valid/ready write port, then fetches one instruction per cycle. Fetch honours stall and branch-redirect requests from the datapath. It stops on an all-zero instruction word or at the end of memory, and flags misaligned branch targets.

---
 rtl/fetch_sequencer_if.sv | 36 +++
 rtl/fetch_sequencer.sv | 88 ++++++++
 tb/tb_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Load port, instruction-memory port and datapath fetch handshake for fetch_sequencer.
// The master modport is the sequencer's view; slave is the datapath/memory side.
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              start;
    logic              loadValid;
    logic [ADDR_W-1:0] loadAddr;
    logic [31:0]       loadData;
    logic              loadReady;
    logic              stall;
    logic              branchTaken;
    logic [31:0]       branchTarget;
    logic [31:0]       memPC;
    logic [31:0]       memRdata;
    logic              memWrite;
    logic [ADDR_W-1:0] memWaddr;
    logic [31:0]       memWdata;
    logic [31:0]       instr;
    logic [31:0]       instrPC;
    logic              instrValid;
    logic              halted;
    logic              error;

    modport master (
        input  start, loadValid, loadAddr, loadData, stall, branchTaken, branchTarget, memRdata,
        output loadReady, memPC, memWrite, memWaddr, memWdata, instr, instrPC, instrValid,
               halted, error
    );

    modport slave (
        output start, loadValid, loadAddr, loadData, stall, branchTaken, branchTarget, memRdata,
        input  loadReady, memPC, memWrite, memWaddr, memWdata, instr, instrPC, instrValid,
               halted, error
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the single-cycle RISC-V datapath: loads instruction memory,
// then fetches one word per cycle with stall, branch redirect and halt detection.
module fetch_sequencer #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic            clock,
    input logic            reset,
    fetch_sequencer_if.master bus
);
    // state | meaning
    // IDLE  | after reset; program load allowed, waiting for start
    // FETCH | one instruction per cycle from memory at pc
    // HALT  | stopped on zero word or end of memory; load allowed
    // ERROR | misaligned branch target seen; waiting for start
    typedef enum logic [1:0] {IDLE, FETCH, HALT, ERROR} state_t;

    localparam logic [29:0] END_WORD = 30'(DEPTH);

    state_t            state;
    logic [31:0]       pc;
    logic [31:0]       instr_q;
    logic [31:0]       instr_pc_q;
    logic              instr_valid_q;
    logic              halted_q;
    logic              error_q;
    logic [ADDR_W-1:0] waddr;

    assign bus.loadReady  = reset && (state == IDLE || state == HALT);
    assign bus.memWrite   = bus.loadValid && bus.loadReady;
    assign waddr          = bus.loadAddr;
    assign bus.memWaddr   = waddr;
    assign bus.memWdata   = bus.loadData;
    assign bus.memPC      = pc;
    assign bus.instr      = instr_q;
    assign bus.instrPC    = instr_pc_q;
    assign bus.instrValid = instr_valid_q;
    assign bus.halted     = halted_q;
    assign bus.error      = error_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.branchTaken) begin
                        // a redirect always flushes, even when the datapath is stalled
                        instr_valid_q <= 1'b0;
                        if (bus.branchTarget[1:0] == 2'b00) begin
                            pc <= bus.branchTarget;
                        end else begin
                            error_q <= 1'b1;
                            state   <= ERROR;
                        end
                    end else if (bus.stall) begin
                        pc <= pc;
                    end else if (pc[31:2] >= END_WORD || bus.memRdata == 32'h0) begin
                        // pc stays on the stopping address so memPC shows where fetch ended
                        instr_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                        state         <= HALT;
                    end else begin
                        instr_q       <= bus.memRdata;
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        pc            <= pc + 32'd4;
                    end
                end
                default: begin
                    if (bus.start) begin
                        pc       <= RESET_PC;
                        halted_q <= 1'b0;
                        error_q  <= 1'b0;
                        state    <= FETCH;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table for fetch/stall/branch/halt
// plus hand sequences for reset, full-depth fetch, load-with-start and reset mid-fetch.
module tb_fetch_sequencer;
    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fetch_sequencer_if #(.ADDR_W(5)) bus ();

    fetch_sequencer #(.DEPTH(32), .ADDR_W(5), .RESET_PC(32'h0)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem [32];

    always @(posedge clock) begin
        if (bus.memWrite) mem[bus.memWaddr] <= bus.memWdata;
    end

    always_comb begin
        bus.memRdata = 32'h0;
        if (bus.memPC[31:2] < 30'd32) bus.memRdata = mem[bus.memPC[6:2]];
    end

    typedef struct {
        logic        st;
        logic        sl;
        logic        br;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] ipc;
        logic [31:0] mpc;
        logic        eh;
        logic        ee;
        logic        elr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic st, input logic sl, input logic br, input logic [31:0] tgt,
                               input logic ev, input logic [31:0] ipc, input logic [31:0] mpc,
                               input logic eh, input logic ee, input logic elr);
        vec_t r;
        r.st = st; r.sl = sl; r.br = br; r.tgt = tgt; r.ev = ev;
        r.ipc = ipc; r.mpc = mpc; r.eh = eh; r.ee = ee; r.elr = elr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.stall = 1'b0; bus.branchTaken = 1'b0; bus.branchTarget = 32'h0;
        bus.loadValid = 1'b0; bus.loadAddr = 5'd0; bus.loadData = 32'h0;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [31:0] d);
        bus.loadValid = 1'b1; bus.loadAddr = a; bus.loadData = d;
        #1;
        chk("load_memWrite", {31'h0, bus.memWrite}, 32'h1);
        cyc();
        bus.loadValid = 1'b0;
    endtask

    localparam logic [31:0] INSN = 32'h001080B3;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        idle_inputs();
        reset = 1'b0;
        bus.loadValid = 1'b1;
        #12;
        chk("rst_instrValid", {31'h0, bus.instrValid}, 32'h0);
        chk("rst_instrPC", bus.instrPC, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_memPC", bus.memPC, 32'h0);
        chk("rst_halted", {31'h0, bus.halted}, 32'h0);
        chk("rst_error", {31'h0, bus.error}, 32'h0);
        chk("rst_loadReady", {31'h0, bus.loadReady}, 32'h0);
        chk("rst_memWrite", {31'h0, bus.memWrite}, 32'h0);
        bus.loadValid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        cyc();
        chk("idle_loadReady", {31'h0, bus.loadReady}, 32'h1);

        load_word(5'd0, INSN);
        load_word(5'd1, INSN);
        load_word(5'd2, INSN);
        load_word(5'd3, 32'h0);

        //            st sl br tgt      ev ipc  mpc    h  e  lr
        tbl.push_back(v(1, 0, 0, 32'h0,  0, 0,   0,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 0,   4,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 4,   8,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 8,   12,    0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  0, 8,   12,    1, 0, 1));
        tbl.push_back(v(0, 0, 0, 32'h0,  0, 8,   12,    1, 0, 1));
        tbl.push_back(v(1, 0, 0, 32'h0,  0, 8,   0,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 0,   4,     0, 0, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,  1, 0,   4,     0, 0, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,  1, 0,   4,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 4,   8,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 8,   12,    0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  0, 8,   12,    1, 0, 1));
        tbl.push_back(v(1, 0, 0, 32'h0,  0, 8,   0,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 0,   4,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 4,   8,     0, 0, 0));
        tbl.push_back(v(0, 1, 1, 32'h0,  0, 4,   0,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 0,   4,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 4,   8,     0, 0, 0));
        tbl.push_back(v(0, 0, 1, 32'h6,  0, 4,   8,     0, 1, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  0, 4,   8,     0, 1, 0));
        tbl.push_back(v(1, 0, 0, 32'h0,  0, 4,   0,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 0,   4,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 4,   8,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 8,   12,    0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  0, 8,   12,    1, 0, 1));
        tbl.push_back(v(1, 0, 0, 32'h0,  0, 8,   0,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 0,   4,     0, 0, 0));
        tbl.push_back(v(0, 0, 1, 32'h80, 0, 0,   32'h80, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  0, 0,   32'h80, 1, 0, 1));
        tbl.push_back(v(1, 0, 0, 32'h0,  0, 0,   0,     0, 0, 0));
        tbl.push_back(v(1, 0, 0, 32'h0,  1, 0,   4,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 4,   8,     0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  1, 8,   12,    0, 0, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,  0, 8,   12,    1, 0, 1));

        foreach (tbl[i]) begin
            bus.start = tbl[i].st; bus.stall = tbl[i].sl;
            bus.branchTaken = tbl[i].br; bus.branchTarget = tbl[i].tgt;
            cyc();
            chk($sformatf("v%0d_instrValid", i), {31'h0, bus.instrValid}, {31'h0, tbl[i].ev});
            chk($sformatf("v%0d_instrPC", i), bus.instrPC, tbl[i].ipc);
            chk($sformatf("v%0d_memPC", i), bus.memPC, tbl[i].mpc);
            chk($sformatf("v%0d_halted", i), {31'h0, bus.halted}, {31'h0, tbl[i].eh});
            chk($sformatf("v%0d_error", i), {31'h0, bus.error}, {31'h0, tbl[i].ee});
            chk($sformatf("v%0d_loadReady", i), {31'h0, bus.loadReady}, {31'h0, tbl[i].elr});
            if (tbl[i].ev) chk($sformatf("v%0d_instr", i), bus.instr, INSN);
        end
        idle_inputs();

        // start together with an accepted load: the first fetch sees the new word
        bus.start = 1'b1; bus.loadValid = 1'b1; bus.loadAddr = 5'd0; bus.loadData = 32'hABCD0001;
        #1;
        chk("startload_memWrite", {31'h0, bus.memWrite}, 32'h1);
        cyc();
        idle_inputs();
        chk("startload_memPC", bus.memPC, 32'h0);
        cyc();
        chk("startload_instrValid", {31'h0, bus.instrValid}, 32'h1);
        chk("startload_instr", bus.instr, 32'hABCD0001);
        k = 0;
        while (!bus.halted && k < 10) begin cyc(); k++; end
        chk("startload_halted", {31'h0, bus.halted}, 32'h1);

        // full-depth program runs off the end of memory
        for (int i = 0; i < 32; i++) load_word(5'(i), 32'h100 + 32'(i));
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cyc();
            chk($sformatf("full_instrValid%0d", i), {31'h0, bus.instrValid}, 32'h1);
            chk($sformatf("full_instrPC%0d", i), bus.instrPC, 32'(4 * i));
            chk($sformatf("full_instr%0d", i), bus.instr, 32'h100 + 32'(i));
        end
        cyc();
        chk("full_halted", {31'h0, bus.halted}, 32'h1);
        chk("full_instrValid_end", {31'h0, bus.instrValid}, 32'h0);
        chk("full_memPC", bus.memPC, 32'h80);

        // asynchronous reset in the middle of a fetch run
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc(); cyc(); cyc();
        chk("mid_instrPC_before", bus.instrPC, 32'h8);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_instrValid", {31'h0, bus.instrValid}, 32'h0);
        chk("mid_instrPC", bus.instrPC, 32'h0);
        chk("mid_instr", bus.instr, 32'h0);
        chk("mid_memPC", bus.memPC, 32'h0);
        chk("mid_halted", {31'h0, bus.halted}, 32'h0);
        chk("mid_loadReady", {31'h0, bus.loadReady}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        cyc(); cyc(); cyc();
        chk("postrst_instrValid", {31'h0, bus.instrValid}, 32'h0);
        chk("postrst_memPC", bus.memPC, 32'h0);
        chk("postrst_loadReady", {31'h0, bus.loadReady}, 32'h1);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        chk("restart_instrPC0", bus.instrPC, 32'h0);
        chk("restart_instr0", bus.instr, 32'h100);
        cyc();
        chk("restart_instrPC1", bus.instrPC, 32'h4);
        chk("restart_instr1", bus.instr, 32'h101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
